// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan scheduler.
// Optional feature macro used by the top: SSD_LZ_BLANK_EN (leading-zero blanking).
package ssd_pkg;

  // Digits per display frame.
  localparam int NIBBLES = 4;

  // Arbiter state: nobody owns the display, or A / B owns it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  // Requester identity, used to remember who was served last.
  typedef enum logic {
    REQ_ID_A = 1'b0,
    REQ_ID_B = 1'b1
  } req_id_t;

  // Pick the hex nibble for digit index sel (digit 0 is data[3:0]).
  function automatic logic [3:0] nibble_sel(input logic [15:0] data, input logic [1:0] sel);
    return data[{sel, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/ssd_scan_timer.sv
// Digit-slot prescaler and scan counter: o_tick marks the last clock of a
// slot, o_frame_end marks the last clock of digit 3 (end of a frame).
module ssd_scan_timer #(
  parameter int DIV = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_tick,
  output logic       o_frame_end,
  output logic [1:0] o_scan_sel
);

  localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_sel;

  assign o_tick      = (r_presc == LAST);
  assign o_frame_end = o_tick && (r_sel == 2'd3);
  assign o_scan_sel  = r_sel;

  // Prescaler counts 0..DIV-1 and wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
    end else if (o_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Active digit advances once per slot, wrapping 3 -> 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel <= 2'd0;
    end else if (o_tick) begin
      r_sel <= r_sel + 2'd1;
    end
  end

endmodule

// File: rtl/ssd_scan_sched.sv
// Two-requester seven-segment display scheduler: frame-granular arbitration
// with a minimum hold, per-frame data snapshot and registered scan outputs.
// Build option: define SSD_LZ_BLANK_EN to blank leading-zero digits.
module ssd_scan_sched
  import ssd_pkg::*;
#(
  parameter int DIV         = 100000,
  parameter int HOLD_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [15:0] data_a,
  input  logic [15:0] data_b,
  output logic        grant_a,
  output logic        grant_b,
  output logic [1:0]  scan_sel,
  output logic [3:0]  digit,
  output logic        blank,
  output state_t      dbg_state
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_FRAMES - 1);

  logic        w_tick;
  logic        w_frame_end;
  logic [1:0]  w_sel;

  state_t      r_state;
  logic [3:0]  r_hold;
  req_id_t     r_last;
  logic [15:0] r_snap;
  logic        r_grant_a;
  logic        r_grant_b;
  logic [3:0]  r_digit;
  logic        r_blank;

  state_t      w_state_nxt;
  logic [3:0]  w_hold_nxt;
  req_id_t     w_last_nxt;
  logic [15:0] w_snap_nxt;
  logic [1:0]  w_sel_nxt;
  logic [3:0]  w_digit_nxt;
  logic        w_blank_nxt;

  ssd_scan_timer #(.DIV(DIV)) u_timer (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .o_tick      (w_tick),
    .o_frame_end (w_frame_end),
    .o_scan_sel  (w_sel)
  );

  // Both requesting: alternate away from whoever was served last.
  function automatic state_t arbitrate(input logic ra, input logic rb, input req_id_t last);
    if (ra && rb)  return (last == REQ_ID_B) ? OWN_A : OWN_B;
    else if (ra)   return OWN_A;
    else if (rb)   return OWN_B;
    else           return IDLE;
  endfunction

  // Next-state, hold, snapshot and last-served decisions; all change only at frame end.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_last_nxt  = r_last;
    w_snap_nxt  = r_snap;
    if (w_frame_end) begin
      case (r_state)
        IDLE:    w_state_nxt = arbitrate(req_a, req_b, r_last);
        OWN_A: begin
          if (!req_a)                        w_state_nxt = arbitrate(1'b0, req_b, r_last);
          else if (r_hold == 4'd0 && req_b)  w_state_nxt = OWN_B;
          else                               w_state_nxt = OWN_A;
        end
        OWN_B: begin
          if (!req_b)                        w_state_nxt = arbitrate(req_a, 1'b0, r_last);
          else if (r_hold == 4'd0 && req_a)  w_state_nxt = OWN_A;
          else                               w_state_nxt = OWN_B;
        end
        default: w_state_nxt = IDLE;
      endcase
      // New owner (or an expired hold that is kept) reloads; otherwise count down.
      if (w_state_nxt == IDLE)                                w_hold_nxt = 4'd0;
      else if (w_state_nxt != r_state || r_hold == 4'd0)      w_hold_nxt = HOLD_LOAD;
      else                                                    w_hold_nxt = r_hold - 4'd1;
      // One consistent sample of the owner's data per frame.
      if (w_state_nxt == OWN_A) begin
        w_snap_nxt = data_a;
        w_last_nxt = REQ_ID_A;
      end else if (w_state_nxt == OWN_B) begin
        w_snap_nxt = data_b;
        w_last_nxt = REQ_ID_B;
      end
    end
  end

  // Digit value is looked up from the next snapshot and next scan index so it
  // changes on the same edge as scan_sel.
  assign w_sel_nxt   = w_tick ? (w_sel + 2'd1) : w_sel;
  assign w_digit_nxt = nibble_sel(w_snap_nxt, w_sel_nxt);

`ifdef SSD_LZ_BLANK_EN
  logic w_lz;

  // Digit k>=1 is dark when it and every higher nibble are zero.
  always_comb begin
    w_lz = 1'b0;
    case (w_sel_nxt)
      2'd1:    w_lz = (w_snap_nxt[15:4]  == 12'h000);
      2'd2:    w_lz = (w_snap_nxt[15:8]  == 8'h00);
      2'd3:    w_lz = (w_snap_nxt[15:12] == 4'h0);
      default: w_lz = 1'b0;
    endcase
  end

  assign w_blank_nxt = (w_state_nxt == IDLE) || w_lz;
`else
  assign w_blank_nxt = (w_state_nxt == IDLE);
`endif

  // Arbiter FSM and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_hold    <= 4'd0;
      r_last    <= REQ_ID_B;
      r_snap    <= 16'h0000;
      r_grant_a <= 1'b0;
      r_grant_b <= 1'b0;
      r_digit   <= 4'h0;
      r_blank   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_hold    <= w_hold_nxt;
      r_last    <= w_last_nxt;
      r_snap    <= w_snap_nxt;
      r_grant_a <= (w_state_nxt == OWN_A);
      r_grant_b <= (w_state_nxt == OWN_B);
      r_digit   <= w_digit_nxt;
      r_blank   <= w_blank_nxt;
    end
  end

  assign grant_a   = r_grant_a;
  assign grant_b   = r_grant_b;
  assign scan_sel  = w_sel;
  assign digit     = r_digit;
  assign blank     = r_blank;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ssd_scan_sched.sv
// Bench for ssd_scan_sched with DIV=4 (4 clocks per digit slot, 16 per frame)
// and HOLD_FRAMES=2. Expected per-slot words {grant_a, grant_b, scan_sel,
// digit, blank} are queued per scenario and compared mid-slot.
module tb_ssd_scan_sched;
  import ssd_pkg::*;

  localparam int W = 9;
`ifdef SSD_LZ_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic [15:0] data_a = 16'h0;
  logic [15:0] data_b = 16'h0;
  logic        grant_a;
  logic        grant_b;
  logic [1:0]  scan_sel;
  logic [3:0]  digit;
  logic        blank;
  state_t      dbg_state;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  ssd_scan_sched #(.DIV(4), .HOLD_FRAMES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .req_b     (req_b),
    .data_a    (data_a),
    .data_b    (data_b),
    .grant_a   (grant_a),
    .grant_b   (grant_b),
    .scan_sel  (scan_sel),
    .digit     (digit),
    .blank     (blank),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Leading-zero blank expectation for digit sel of snapshot s.
  function automatic logic lz_blank(input logic [15:0] s, input int sel);
    return LZ_EN && (sel != 0) && ((s >> (4 * sel)) == 16'h0);
  endfunction

  // kind: 0 idle, 1 owned by A, 2 owned by B; snap is the displayed sample.
  task automatic push_frame(input int kind, input logic [15:0] snap);
    logic [3:0] nib;
    logic [1:0] s2;
    for (int s = 0; s < 4; s++) begin
      nib = snap[s*4 +: 4];
      s2  = 2'(s);
      if (kind == 0)      exp_q.push_back({1'b0, 1'b0, s2, nib, 1'b1});
      else if (kind == 1) exp_q.push_back({1'b1, 1'b0, s2, nib, lz_blank(snap, s)});
      else                exp_q.push_back({1'b0, 1'b1, s2, nib, lz_blank(snap, s)});
    end
  endtask

  // Driver: reset with current inputs, then move to the middle of slot 0.
  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Sample the current slot, then advance to the middle of the next one.
  task automatic get_slot(output logic [W-1:0] obs);
    obs = {grant_a, grant_b, scan_sel, digit, blank};
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [W-1:0] obs, e;
    req_a = 1'b0; req_b = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    obs = {grant_a, grant_b, scan_sel, digit, blank};
    e = {1'b0, 1'b0, 2'd0, 4'h0, 1'b1};
    total++;
    if (obs !== e) begin bad++; $display("FAIL reset_values got=%b want=%b (ga gb sel dig blk)", obs, e); end
    total++;
    if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Scan index must step exactly every 4 clocks after release.
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_q.push_back({1'b0, 1'b0, 2'((k / 4) % 4), 4'h0, 1'b1});
      obs = {grant_a, grant_b, scan_sel, digit, blank};
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL idle_scan clk=%0d got=%b want=%b (ga gb sel dig blk)", k, obs, e); end
    end
  endtask

  task automatic test_a_only();
    logic [W-1:0] obs, e;
    int i = 0;
    req_a = 1'b1; req_b = 1'b0; data_a = 16'h12AF;
    reset_dut();
    push_frame(0, 16'h0);
    push_frame(1, 16'h12AF);
    push_frame(1, 16'h12AF);
    while (exp_q.size() > 0) begin
      get_slot(obs);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL a_only slot=%0d got=%b want=%b (ga gb sel dig blk)", i, obs, e); end
      i++;
    end
  endtask

  task automatic test_both_alternate();
    logic [W-1:0] obs, e;
    logic [15:0] da, db;
    int i = 0;
    da = 16'($urandom_range(16'h1000, 16'hFFFF));
    db = 16'($urandom_range(16'h1000, 16'hFFFF));
    req_a = 1'b1; req_b = 1'b1; data_a = da; data_b = db;
    reset_dut();
    push_frame(0, 16'h0);
    push_frame(1, da); push_frame(1, da);
    push_frame(2, db); push_frame(2, db);
    push_frame(1, da); push_frame(1, da);
    push_frame(2, db);
    while (exp_q.size() > 0) begin
      get_slot(obs);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL both_alt slot=%0d got=%b want=%b (ga gb sel dig blk)", i, obs, e); end
      i++;
    end
  endtask

  task automatic test_release_idle();
    logic [W-1:0] obs, e;
    logic [15:0] da;
    int i = 0;
    da = 16'($urandom_range(0, 16'hFFFF));
    req_a = 1'b1; req_b = 1'b0; data_a = da;
    reset_dut();
    push_frame(0, 16'h0);
    push_frame(1, da);
    push_frame(0, da);
    while (exp_q.size() > 0) begin
      if (i == 6) begin
        req_a  = 1'b0;
        data_a = ~da;
      end
      get_slot(obs);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL release_idle slot=%0d got=%b want=%b (ga gb sel dig blk)", i, obs, e); end
      i++;
    end
  endtask

  task automatic test_refresh_hold();
    logic [W-1:0] obs, e;
    logic [15:0] d[4];
    int i = 0;
    for (int k = 0; k < 4; k++) d[k] = 16'($urandom_range(0, 16'hFFFF));
    req_a = 1'b1; req_b = 1'b0; data_a = d[0];
    reset_dut();
    push_frame(0, 16'h0);
    for (int k = 0; k < 4; k++) push_frame(1, d[k]);
    while (exp_q.size() > 0) begin
      if (i == 6)  data_a = d[1];
      if (i == 10) data_a = d[2];
      if (i == 14) data_a = d[3];
      get_slot(obs);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL refresh_hold slot=%0d got=%b want=%b (ga gb sel dig blk)", i, obs, e); end
      i++;
    end
  endtask

  task automatic test_release_switch();
    logic [W-1:0] obs, e;
    logic [15:0] da, db;
    int i = 0;
    da = 16'($urandom_range(0, 16'hFFFF));
    db = 16'($urandom_range(0, 16'hFFFF));
    req_a = 1'b1; req_b = 1'b0; data_a = da; data_b = db;
    reset_dut();
    push_frame(0, 16'h0);
    push_frame(1, da);
    push_frame(2, db);
    push_frame(2, db);
    while (exp_q.size() > 0) begin
      if (i == 4) begin
        req_a = 1'b0;
        req_b = 1'b1;
      end
      get_slot(obs);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL release_switch slot=%0d got=%b want=%b (ga gb sel dig blk)", i, obs, e); end
      i++;
    end
  endtask

  task automatic test_leading_zero();
    logic [W-1:0] obs, e;
    int i = 0;
    req_a = 1'b1; req_b = 1'b0; data_a = 16'h0005;
    reset_dut();
    push_frame(0, 16'h0);
    push_frame(1, 16'h0005);
    push_frame(1, 16'h0300);
    while (exp_q.size() > 0) begin
      if (i == 6) data_a = 16'h0300;
      get_slot(obs);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL leading_zero slot=%0d got=%b want=%b (ga gb sel dig blk)", i, obs, e); end
      i++;
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] obs, e;
    logic [15:0] da, db;
    da = 16'($urandom_range(0, 16'hFFFF));
    db = 16'($urandom_range(0, 16'hFFFF));
    req_a = 1'b1; req_b = 1'b1; data_a = da; data_b = db;
    reset_dut();
    push_frame(0, 16'h0);
    push_frame(1, da); push_frame(1, da);
    push_frame(2, db);
    for (int i = 0; i < 14; i++) begin
      get_slot(obs);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL async_pre slot=%0d got=%b want=%b (ga gb sel dig blk)", i, obs, e); end
    end
    exp_q.delete();
    total++;
    if (dbg_state !== OWN_B) begin bad++; $display("FAIL async_owner got=%0d want=%0d", dbg_state, OWN_B); end
    // Assert reset between clock edges and look before the next edge.
    #1 rst_n = 1'b0;
    #1;
    exp_q.push_back({1'b0, 1'b0, 2'd0, 4'h0, 1'b1});
    obs = {grant_a, grant_b, scan_sel, digit, blank};
    e = exp_q.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL async_reset got=%b want=%b (ga gb sel dig blk)", obs, e); end
    total++;
    if (dbg_state !== IDLE) begin bad++; $display("FAIL async_state got=%0d want=%0d", dbg_state, IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_a_only();
    test_both_alternate();
    test_release_idle();
    test_refresh_hold();
    test_release_switch();
    test_leading_zero();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
